// File: rtl/uart_rx.sv
// UART receive deserializer: synchronises rx, detects the start bit on oversample
// ticks, samples each bit mid-period (LSB first) and flags a low stop bit.
module uart_rx #(
  parameter int DATA_BITS  = 8,
  parameter int OVERSAMPLE = 16
) (
  input  logic                 clk,
  input  logic                 arst_n,
  input  logic                 tick,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] data_out,
  output logic                 rx_done,
  output logic                 frame_err,
  output logic                 busy
);
  localparam int SW = $clog2(OVERSAMPLE);
  localparam int NW = $clog2(DATA_BITS);
  localparam logic [SW-1:0] S_MID  = SW'(OVERSAMPLE / 2 - 1);
  localparam logic [SW-1:0] S_LAST = SW'(OVERSAMPLE - 1);
  localparam logic [NW-1:0] N_LAST = NW'(DATA_BITS - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t               r_state;
  logic [1:0]           r_sync;
  logic [SW-1:0]        r_s_cnt;
  logic [NW-1:0]        r_n_cnt;
  logic [DATA_BITS-1:0] r_shreg;
  logic [DATA_BITS-1:0] r_data_out;
  logic                 r_rx_done;
  logic                 r_frame_err;
  logic                 r_armed;
  logic                 w_rx_s;

  assign w_rx_s    = r_sync[1];
  assign data_out  = r_data_out;
  assign rx_done   = r_rx_done;
  assign frame_err = r_frame_err;
  assign busy      = (r_state != IDLE);

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      r_state     <= IDLE;
      r_sync      <= 2'b11;
      r_s_cnt     <= '0;
      r_n_cnt     <= '0;
      r_shreg     <= '0;
      r_data_out  <= '0;
      r_rx_done   <= 1'b0;
      r_frame_err <= 1'b0;
      r_armed     <= 1'b1;
    end else begin
      r_sync    <= {r_sync[0], rx};
      r_rx_done <= 1'b0;
      if (tick) begin
        case (r_state)
          IDLE: begin
            // armed blocks a held-low line (break) from retriggering frames
            if (w_rx_s) begin
              r_armed <= 1'b1;
            end else if (r_armed) begin
              r_state <= START;
              r_s_cnt <= '0;
            end
          end
          START: begin
            if (r_s_cnt == S_MID) begin
              if (w_rx_s) begin
                r_state <= IDLE;
              end else begin
                r_state <= DATA;
                r_s_cnt <= '0;
                r_n_cnt <= '0;
              end
            end else begin
              r_s_cnt <= r_s_cnt + SW'(1);
            end
          end
          DATA: begin
            if (r_s_cnt == S_LAST) begin
              r_shreg <= {w_rx_s, r_shreg[DATA_BITS-1:1]};
              r_s_cnt <= '0;
              if (r_n_cnt == N_LAST) r_state <= STOP;
              else                   r_n_cnt <= r_n_cnt + NW'(1);
            end else begin
              r_s_cnt <= r_s_cnt + SW'(1);
            end
          end
          STOP: begin
            if (r_s_cnt == S_LAST) begin
              r_data_out  <= r_shreg;
              r_frame_err <= ~w_rx_s;
              r_rx_done   <= 1'b1;
              r_armed     <= w_rx_s;
              r_state     <= IDLE;
            end else begin
              r_s_cnt <= r_s_cnt + SW'(1);
            end
          end
          default: r_state <= IDLE;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: frame-level expectation queues per instance,
// one compare process per instance, plus literal checks for the directed cases.
`timescale 1ns/1ps
module tb_uart_rx;
  localparam int TDIV = 4;               // tick divisor, scaled down from 325 for run time
  localparam int OS0 = 16, DB0 = 8;
  localparam int OS1 = 8,  DB1 = 7;      // second instance: tick held high every clk

  logic clk = 1'b0;
  logic arst_n;
  logic tick0 = 1'b0;
  logic tick1 = 1'b1;
  logic rx0 = 1'b1, rx1 = 1'b1;
  logic [DB0-1:0] dout0;
  logic [DB1-1:0] dout1;
  logic done0, fe0, busy0, done1, fe1, busy1;

  int errors = 0, checks = 0, cyc = 0, tdiv_cnt = 0;
  int done_cnt0 = 0, done_cnt1 = 0;
  int m_data0 = 0, m_fe0 = 0, m_data1 = 0, m_fe1 = 0;
  logic prev_done0 = 1'b0, prev_done1 = 1'b0;

  typedef struct {int data; int fe; int t0;} exp_t;
  exp_t q0[$], q1[$];

  uart_rx #(.DATA_BITS(DB0), .OVERSAMPLE(OS0)) dut0 (
    .clk(clk), .arst_n(arst_n), .tick(tick0), .rx(rx0),
    .data_out(dout0), .rx_done(done0), .frame_err(fe0), .busy(busy0));

  uart_rx #(.DATA_BITS(DB1), .OVERSAMPLE(OS1)) dut1 (
    .clk(clk), .arst_n(arst_n), .tick(tick1), .rx(rx1),
    .data_out(dout1), .rx_done(done1), .frame_err(fe1), .busy(busy1));

  always #10 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) begin
    tick0    <= (tdiv_cnt == TDIV - 1);
    tdiv_cnt <= (tdiv_cnt == TDIV - 1) ? 0 : tdiv_cnt + 1;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Nominal start-edge-to-done latency: (1.5 + DATA_BITS) bit periods, in clk cycles.
  function automatic int nominal(input int nb, input int os, input int div);
    return ((2 * nb + 3) * os * div) / 2;
  endfunction

  always @(negedge clk) begin : cmp0
    exp_t e;
    int lat, nom;
    if (!arst_n) begin
      chk("rst_data0", dout0, 0);
      chk("rst_done0", done0, 0);
      chk("rst_ferr0", fe0, 0);
      chk("rst_busy0", busy0, 0);
      m_data0 = 0; m_fe0 = 0; q0.delete();
    end else if (done0) begin
      done_cnt0++;
      chk("done0_one_cycle", prev_done0, 0);
      if (q0.size() == 0) begin
        chk("done0_unexpected", 1, 0);
      end else begin
        e = q0.pop_front();
        lat = cyc - e.t0;
        nom = nominal(DB0, OS0, TDIV);
        chk("data0", dout0, e.data);
        chk("ferr0", fe0, e.fe);
        chk("latency0_in_window", (lat >= nom - 2) && (lat <= nom + 4 + TDIV), 1);
        m_data0 = e.data; m_fe0 = e.fe;
        $display("rx0 frame %0d: data=0x%02h ferr=%0d latency=%0d", done_cnt0, dout0, fe0, lat);
      end
    end else begin
      chk("hold_data0", dout0, m_data0);
      chk("hold_ferr0", fe0, m_fe0);
    end
    prev_done0 = arst_n ? done0 : 1'b0;
  end

  always @(negedge clk) begin : cmp1
    exp_t e;
    int lat, nom;
    if (!arst_n) begin
      chk("rst_data1", dout1, 0);
      chk("rst_done1", done1, 0);
      chk("rst_ferr1", fe1, 0);
      m_data1 = 0; m_fe1 = 0; q1.delete();
    end else if (done1) begin
      done_cnt1++;
      chk("done1_one_cycle", prev_done1, 0);
      if (q1.size() == 0) begin
        chk("done1_unexpected", 1, 0);
      end else begin
        e = q1.pop_front();
        lat = cyc - e.t0;
        nom = nominal(DB1, OS1, 1);
        chk("data1", dout1, e.data);
        chk("ferr1", fe1, e.fe);
        chk("latency1_in_window", (lat >= nom - 2) && (lat <= nom + 5), 1);
        m_data1 = e.data; m_fe1 = e.fe;
        $display("rx1 frame %0d: data=0x%02h ferr=%0d latency=%0d", done_cnt1, dout1, fe1, lat);
      end
    end else begin
      chk("hold_data1", dout1, m_data1);
      chk("hold_ferr1", fe1, m_fe1);
    end
    prev_done1 = arst_n ? done1 : 1'b0;
  end

  // Wait n ticks of instance u; returns 1 ns after the n-th ticking edge.
  task automatic wt(input int u, input int n);
    if (u == 0) repeat (n) begin
      do @(posedge clk); while (!tick0);
    end else repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drv(input int u, input logic v);
    if (u == 0) rx0 = v; else rx1 = v;
  endtask

  // One frame: start, data LSB first, stop bit of the given level.
  task automatic send(input int u, input logic [7:0] d, input bit stop, input bit glitch);
    exp_t e;
    int nb = (u == 0) ? DB0 : DB1;
    int os = (u == 0) ? OS0 : OS1;
    drv(u, 1'b0);
    e.data = int'(d) & ((1 << nb) - 1);
    e.fe = stop ? 0 : 1;
    e.t0 = cyc;
    if (u == 0) q0.push_back(e); else q1.push_back(e);
    wt(u, os);
    for (int i = 0; i < nb; i++) begin
      drv(u, d[i]);
      if (glitch && u == 0 && $urandom_range(0, 1) == 1) begin
        // one-clk spike well away from the mid-bit sample point
        wt(u, 2); drv(u, ~d[i]); @(posedge clk); #1; drv(u, d[i]);
        wt(u, os - 2);
      end else begin
        wt(u, os);
      end
    end
    drv(u, stop);
    wt(u, os);
  endtask

  initial begin : timeout
    #1_500_000;
    $display("FAIL timeout: bench did not finish, errors=%0d checks=%0d", errors, checks);
    $fatal(1);
  end

  initial begin : stim
    logic [7:0] c3, d;
    bit stop;
    arst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_data_out", dout0, 8'h00);
    chk("reset_busy", busy0, 0);
    arst_n = 1'b1;
    wt(0, OS0 * 2);

    // clean byte
    send(0, 8'hA5, 1, 0);
    wt(0, OS0);
    chk("a5_data", dout0, 8'hA5);
    chk("a5_ferr", fe0, 0);
    chk("a5_busy_after", busy0, 0);
    chk("a5_done_count", done_cnt0, 1);

    // back-to-back, no idle gap
    send(0, 8'h00, 1, 0);
    send(0, 8'hFF, 1, 0);
    send(0, 8'h3C, 1, 0);
    wt(0, OS0);
    chk("b2b_last_data", dout0, 8'h3C);
    chk("b2b_done_count", done_cnt0, 4);

    // false start: low for 4 ticks only
    rx0 = 1'b0;
    wt(0, 4);
    chk("false_start_busy", busy0, 1);
    rx0 = 1'b1;
    wt(0, OS0);
    chk("false_start_idle", busy0, 0);
    chk("false_start_no_done", done_cnt0, 4);
    chk("false_start_data_kept", dout0, 8'h3C);

    // framing error, then break held for three frame times
    send(0, 8'h55, 0, 0);
    rx0 = 1'b0;
    wt(0, OS0 * 30);
    chk("break_done_count", done_cnt0, 5);
    chk("break_data", dout0, 8'h55);
    chk("break_ferr", fe0, 1);
    rx0 = 1'b1;
    wt(0, OS0);
    send(0, 8'h12, 1, 0);
    wt(0, OS0);
    chk("after_break_data", dout0, 8'h12);
    chk("after_break_ferr", fe0, 0);

    // reset in the middle of data bit 4 of 0xC3
    c3 = 8'hC3;
    rx0 = 1'b0;
    wt(0, OS0);
    for (int i = 0; i < 4; i++) begin
      rx0 = c3[i];
      wt(0, OS0);
    end
    rx0 = c3[4];
    wt(0, OS0 / 2);
    chk("midframe_busy", busy0, 1);
    arst_n = 1'b0;
    #1;
    chk("midrst_data", dout0, 8'h00);
    chk("midrst_busy", busy0, 0);
    chk("midrst_ferr", fe0, 0);
    repeat (3) @(posedge clk);
    #1;
    rx0 = 1'b1;
    arst_n = 1'b1;
    wt(0, OS0 * 2);
    send(0, 8'h81, 1, 0);
    wt(0, OS0);
    chk("after_rst_data", dout0, 8'h81);
    chk("after_rst_done_count", done_cnt0, 7);

    // randomized frames with spikes, occasional framing errors and gaps
    for (int k = 0; k < 20; k++) begin
      d = 8'($urandom);
      stop = ($urandom_range(0, 5) != 0);
      send(0, d, stop, 1);
      rx0 = 1'b1;
      wt(0, OS0 * (stop ? $urandom_range(0, 2) : $urandom_range(1, 2)));
    end
    wt(0, OS0 * 2);
    chk("rand0_all_received", q0.size(), 0);
    chk("rand0_done_count", done_cnt0, 27);

    // 7-bit, 8x oversample, tick every clk
    wt(1, OS1 * 2);
    send(1, 8'h5A, 1, 0);
    wt(1, OS1 * 2);
    chk("sweep_data", dout1, 7'h5A);
    chk("sweep_ferr", fe1, 0);
    chk("sweep_done_once", done_cnt1, 1);
    for (int k = 0; k < 6; k++) send(1, 8'($urandom), 1, 0);
    wt(1, OS1 * 2);
    chk("rand1_all_received", q1.size(), 0);
    chk("rand1_busy_idle", busy1, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
